// File: rtl/bcd_scan_ctrl.sv
// Iterative double-dabble binary-to-BCD converter with a held display register and a
// four-digit multiplexed 7-segment scan for a common-anode display.
module bcd_scan_ctrl #(
    parameter int unsigned CLK_DIV       = 50000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  value_in,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd_out,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int unsigned PresW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PresW-1:0] PresMax = PresW'(CLK_DIV - 1);
    localparam logic [3:0] LastIter = 4'd9;

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StUpdate
    } state_e;

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [15:0]       bcd_q, bcd_d;
    logic [15:0]       scratch_q, scratch_d;
    logic [9:0]        shift_q, shift_d;
    logic [3:0]        iter_q, iter_d;
    logic [PresW-1:0]  pres_q, pres_d;
    logic [1:0]        idx_q, idx_d;

    logic [15:0]       scratch_adj;
    logic [3:0]        digit;
    logic              blank_thou;
    logic              blank_hund;
    logic              blank_tens;
    logic              slot_blank;

    // Nibbles >= 5 would overflow past 9 after doubling, so pre-correct them by 3.
    function automatic logic [15:0] dd_adjust(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int i = 0; i < 4; i++) begin
            if (s[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign scratch_adj = dd_adjust(scratch_q);

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        scratch_d = scratch_q;
        shift_d   = shift_q;
        iter_d    = iter_q;

        unique case (state_q)
            StIdle: begin
                if (load) begin
                    shift_d   = value_in;
                    scratch_d = '0;
                    iter_d    = '0;
                    busy_d    = 1'b1;
                    state_d   = StConvert;
                end
            end
            StConvert: begin
                {scratch_d, shift_d} = {scratch_adj[14:0], shift_q, 1'b0};
                iter_d = iter_q + 4'd1;
                if (iter_q == LastIter) begin
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                bcd_d   = scratch_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Refresh scan runs freely, independent of the conversion FSM.
    always_comb begin
        pres_d = pres_q + PresW'(1);
        idx_d  = idx_q;
        if (pres_q == PresMax) begin
            pres_d = '0;
            idx_d  = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            scratch_q <= '0;
            shift_q   <= '0;
            iter_q    <= '0;
            pres_q    <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            scratch_q <= scratch_d;
            shift_q   <= shift_d;
            iter_q    <= iter_d;
            pres_q    <= pres_d;
            idx_q     <= idx_d;
        end
    end

    always_comb begin
        digit = bcd_q[3:0];
        unique case (idx_q)
            2'd0: digit = bcd_q[3:0];
            2'd1: digit = bcd_q[7:4];
            2'd2: digit = bcd_q[11:8];
            2'd3: digit = bcd_q[15:12];
            default: digit = bcd_q[3:0];
        endcase
    end

    // Leading-zero blanking; an interior zero (e.g. tens of 305) stays lit.
    assign blank_thou = (bcd_q[15:12] == 4'd0);
    assign blank_hund = blank_thou && (bcd_q[11:8] == 4'd0);
    assign blank_tens = blank_hund && (bcd_q[7:4] == 4'd0);

    always_comb begin
        slot_blank = 1'b0;
        unique case (idx_q)
            2'd0: slot_blank = 1'b0;
            2'd1: slot_blank = blank_tens;
            2'd2: slot_blank = blank_hund;
            2'd3: slot_blank = blank_thou;
            default: slot_blank = 1'b0;
        endcase
    end

    assign an = (BLANK_LEADING && slot_blank) ? 4'b1111 : ~(4'b0001 << idx_q);

    // Shared decoder_7seg: active-low segments ordered {g,f,e,d,c,b,a}.
    always_comb begin
        seg = 7'b1111111;
        unique case (digit)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Bench for bcd_scan_ctrl: directed and random loads compared every cycle against an
// arithmetic reference model of conversion timing, BCD value and refresh scan.
module tb_bcd_scan_ctrl;

    localparam int unsigned CD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [9:0]  value_in = '0;

    logic        busy, done, busy_nb, done_nb;
    logic [15:0] bcd_out, bcd_out_nb;
    logic [3:0]  an, an_nb;
    logic [6:0]  seg, seg_nb;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state
    int cyc = 0;
    int remain = 0;
    int pend = 0;
    int disp = 0;
    bit exp_done = 1'b0;

    bcd_scan_ctrl #(.CLK_DIV(CD), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .value_in(value_in), .load(load), .busy(busy),
        .done(done), .bcd_out(bcd_out), .an(an), .seg(seg)
    );

    bcd_scan_ctrl #(.CLK_DIV(CD), .BLANK_LEADING(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .value_in(value_in), .load(load), .busy(busy_nb),
        .done(done_nb), .bcd_out(bcd_out_nb), .an(an_nb), .seg(seg_nb)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int digit_of(input int v, input int pos);
        case (pos)
            0: return v % 10;
            1: return (v / 10) % 10;
            2: return (v / 100) % 10;
            default: return (v / 1000) % 10;
        endcase
    endfunction

    function automatic logic [6:0] seg_pat(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    // A slot is a leading zero when the value has fewer significant digits than its position.
    function automatic bit is_lead(input int v, input int pos);
        case (pos)
            1: return v < 10;
            2: return v < 100;
            3: return v < 1000;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_all();
        int idx;
        logic [15:0] exp_bcd;
        logic [3:0] one;
        logic [3:0] en;
        bit lead;
        one = 4'b0001;
        idx = (cyc / CD) % 4;
        exp_bcd = 16'(digit_of(disp, 3) * 4096 + digit_of(disp, 2) * 256 +
                      digit_of(disp, 1) * 16 + digit_of(disp, 0));
        en = ~(one << idx);
        lead = is_lead(disp, idx);
        check_eq("busy", 32'(busy), 32'(remain > 0));
        check_eq("done", 32'(done), 32'(exp_done));
        check_eq("bcd_out", 32'(bcd_out), 32'(exp_bcd));
        check_eq("an_blank", 32'(an), lead ? 32'hF : 32'(en));
        if (!lead) check_eq("seg_blank", 32'(seg), 32'(seg_pat(digit_of(disp, idx))));
        check_eq("bcd_out_nb", 32'(bcd_out_nb), 32'(exp_bcd));
        check_eq("an_nb", 32'(an_nb), 32'(en));
        check_eq("seg_nb", 32'(seg_nb), 32'(seg_pat(digit_of(disp, idx))));
    endtask

    task automatic tick(input bit ld, input logic [9:0] v);
        load = ld;
        value_in = v;
        @(posedge clk);
        cyc++;
        if (remain == 0) begin
            exp_done = 1'b0;
            if (ld) begin
                remain = 11;
                pend = int'(v);
            end
        end else begin
            remain--;
            exp_done = (remain == 0);
            if (remain == 0) disp = pend;
        end
        #1;
        load = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 10'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        cyc = 0;
        remain = 0;
        disp = 0;
        exp_done = 1'b0;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        idle(20);

        tick(1'b1, 10'd1023);
        idle(24);

        tick(1'b1, 10'd7);
        idle(20);

        // Second load while busy is dropped; a load in the done cycle is accepted.
        tick(1'b1, 10'd500);
        idle(4);
        tick(1'b1, 10'd999);
        idle(6);
        tick(1'b1, 10'd999);
        idle(14);

        tick(1'b1, 10'd305);
        idle(20);

        tick(1'b1, 10'd0);
        idle(14);

        tick(1'b1, 10'd1023);
        idle(5);
        do_reset();
        idle(20);

        for (int i = 0; i < 500; i++) begin
            tick($urandom_range(0, 3) == 0, 10'($urandom_range(0, 1023)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_scan_ctrl.md
Name: bcd_scan_ctrl

Overview:
- Sequential replacement for the combinational divide/modulo BCD path.
- Converts a 10-bit binary value to four BCD digits with an iterative shift-add-3 (double dabble) engine, then holds the result in a display register.
- Time-multiplexes the four digits onto one shared decoder_7seg instance through active-low digit enables.
- Sits between the value source (counter/ROM readout) and the board's 4-digit common-anode display.

Parameters:
- CLK_DIV, 50000, clk cycles per digit slot in the refresh scan (minimum 2).
- BLANK_LEADING, 1, 1 = blank leading zero digits; 0 = always show all four digits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- value_in  input  10  binary value to convert, sampled only on accepted load.
- load  input  1  conversion request, level-sampled each clock.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the display register updates.
- bcd_out  output  16  display register: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
- an  output  4  digit enables, active-low one-hot; an[0] = units ... an[3] = thousands.
- seg  output  7  segment pattern from the shared decoder_7seg for the selected digit.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - state = IDLE, busy = 0, done = 0.
  - bcd_out = 16'h0000, scratch registers = 0.
  - Prescaler = 0, digit index = 0, an = 4'b1110.
  - seg = decoder pattern for 0 (combinational from the digit mux).
- FSM states: IDLE, CONVERT, UPDATE.
  - IDLE: if load = 1 at edge k, capture value_in into the shift register, clear the BCD scratch, set iteration count = 0, go to CONVERT, busy = 1 from edge k.
  - CONVERT: one iteration per clock. First, add 3 to each scratch nibble >= 5. Then shift {scratch, shift register} left 1, inserting the binary MSB into scratch[0]. After 10 iterations (edges k+1..k+10) go to UPDATE.
  - UPDATE (edge k+11): bcd_out <= scratch, done = 1, busy = 0, go to IDLE. done returns to 0 at edge k+12 unless a new conversion completes.
- Latency: load sampled to bcd_out valid is 11 clocks; busy is high for exactly 11 cycles.
- load while busy = 1 is ignored; no queuing.
- load = 1 in the cycle after UPDATE (state IDLE, done = 1) is accepted normally.
- bcd_out only changes at UPDATE. The display never shows partial conversion results.
- Range: value_in 0..1023. Thousands digit is 0 or 1. Every nibble of bcd_out is always <= 9.
- Scan:
  - Prescaler counts 0..CLK_DIV-1 continuously, independent of FSM state.
  - On wrap, digit index advances 0 -> 1 -> 2 -> 3 -> 0.
  - an = ~(4'b0001 << index). Digit mux selects bcd_out nibble [index].
- Blanking (BLANK_LEADING = 1), determined from bcd_out:
  - Thousands is blank if it is 0.
  - Hundreds is blank if thousands and hundreds are both 0.
  - Tens is blank if thousands, hundreds and tens are all 0.
  - Units is never blanked.
  - A blank slot drives an = 4'b1111; seg content is then don't-care.
- Reset asserted mid-conversion: immediate return to reset values. The partial result is discarded and bcd_out = 0.
- All outputs registered except seg (combinational through the decoder) and an (registered index, combinational blank gating).

Test Plan:
- Reset then release, CLK_DIV = 4 -> busy = 0, done = 0, bcd_out = 0000; an cycles 1110 only (upper digits blanked); seg = "0" pattern.
- load with value_in = 10'd1023 -> busy high 11 cycles; done pulses 1 cycle; bcd_out = 16'h1023; an sequence 1110, 1101, 1011, 0111 with 4-clock slots.
- value_in = 10'd7, BLANK_LEADING = 1 -> bcd_out = 16'h0007; an shows 1110 in slot 0 and 1111 in slots 1-3. Same with BLANK_LEADING = 0 -> all four slots enabled, seg = "0" on the upper three.
- load 10'd500, then load again with 10'd999 during busy -> second load ignored; bcd_out = 16'h0500. Load 999 in the done cycle -> accepted; bcd_out = 16'h0999 11 cycles later.
- value_in = 10'd305 -> bcd_out = 16'h0305; tens slot enabled showing "0" (interior zero not blanked).
- rst_n pulsed low at iteration 5 of a 1023 conversion -> busy = 0, bcd_out = 0000 immediately; no done pulse afterwards.
